// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared constants and state encoding for the APB side of the AHB-to-APB bridge
package apb_bridge_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    // write flag sits just above the address in the FIFO address word
    localparam int WR_BIT = ADDR_W_DEF;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts ACCESS cycles without Pready and flags the terminal count
module apb_wait_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout_hit
);
    localparam int W = $clog2(TIMEOUT);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= cnt + W'(1);
    assign timeout_hit = cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/apb_master_fsm.sv
// apb_master_fsm: pops bridge FIFO entries and runs one APB SETUP/ACCESS transfer per entry
module apb_master_fsm
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic              Pclk,
    input  logic              rst,
    input  logic              transfer,
    input  logic [ADDR_W:0]   addr_temp,
    input  logic [DATA_W-1:0] data_temp,
    output logic              pop,
    input  logic              Pready,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              Pslverr,
    output logic              Psel,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              slverr,
    output logic              timeout,
    output logic [CNT_W-1:0]  xfer_count
);
    apb_state_t state, state_nxt;
    logic hit;
    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk        (Pclk),
        .rst        (rst),
        .clear      (state == IDLE && transfer),
        .enable     (state == ACCESS && !Pready),
        .timeout_hit(hit)
    );
    always_ff @(posedge Pclk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state == IDLE   ? (transfer ? SETUP : IDLE) :
                    state == SETUP  ? ACCESS :
                    (state == ACCESS && !pop) ? ACCESS : IDLE;
    end
    always_comb begin
        Psel    = state != IDLE;
        Penable = state == ACCESS;
        pop     = state == ACCESS && (Pready || hit);
    end
    // request fields are captured once in IDLE and held until the next entry
    always_ff @(posedge Pclk or posedge rst)
        if (rst) begin
            Paddr       <= '0;
            Pwrite      <= 1'b0;
            Pwdata      <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            slverr      <= 1'b0;
            timeout     <= 1'b0;
            xfer_count  <= '0;
        end else begin
            if (state == IDLE && transfer) begin
                Paddr  <= addr_temp[ADDR_W-1:0];
                Pwrite <= addr_temp[ADDR_W];
                Pwdata <= data_temp;
            end
            if (pop && Pready && !Pwrite) rdata <= Prdata;
            rdata_valid <= pop && Pready && !Pwrite;
            slverr      <= pop && Pready && Pslverr;
            timeout     <= pop && !Pready;
            if (pop) xfer_count <= xfer_count + CNT_W'(1);
        end
endmodule

// File: tb/tb_apb_master_fsm.sv
// tb_apb_master_fsm: directed and random FIFO entries checked against a transaction-level model
module tb_apb_master_fsm;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam int CW = 4;
    logic          Pclk = 1'b0;
    logic          rst;
    logic          transfer;
    logic [AW:0]   addr_temp;
    logic [DW-1:0] data_temp;
    logic          pop;
    logic          Pready;
    logic [DW-1:0] Prdata;
    logic          Pslverr;
    logic          Psel;
    logic          Penable;
    logic          Pwrite;
    logic [AW-1:0] Paddr;
    logic [DW-1:0] Pwdata;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          slverr;
    logic          timeout;
    logic [CW-1:0] xfer_count;

    apb_master_fsm #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .Pclk(Pclk), .rst(rst), .transfer(transfer), .addr_temp(addr_temp),
        .data_temp(data_temp), .pop(pop), .Pready(Pready), .Prdata(Prdata),
        .Pslverr(Pslverr), .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .rdata(rdata), .rdata_valid(rdata_valid),
        .slverr(slverr), .timeout(timeout), .xfer_count(xfer_count)
    );

    always #5 Pclk = ~Pclk;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] prdata;
        int            waits;
        bit            serr;
    } ent_t;

    ent_t          q[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_count = '0;
    logic [DW-1:0] exp_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] pr, input int w, input bit se);
        ent_t e;
        e.wr = wr; e.addr = a; e.data = d; e.prdata = pr; e.waits = w; e.serr = se;
        q.push_back(e);
    endtask

    // acts as FIFO and APB slave; each entry's outcome follows from its wait count alone
    task automatic run(input string tag, input int budget);
        int   cyc = 0;
        int   acc = 0;
        int   setups = 0;
        int   bad = 0;
        bit   post = 0;
        bit   p_rv = 0, p_se = 0, p_to = 0, to;
        ent_t h;
        while ((q.size() > 0 || post) && cyc < budget) begin
            @(negedge Pclk);
            cyc++;
            transfer = q.size() > 0;
            if (transfer) begin
                addr_temp = {q[0].wr, q[0].addr};
                data_temp = q[0].data;
            end
            #1;
            if (post) begin
                chk({tag, "_idle_gap"}, 64'(Psel), 64'(0));
                chk({tag, "_rdata_valid"}, 64'(rdata_valid), 64'(p_rv));
                chk({tag, "_slverr"}, 64'(slverr), 64'(p_se));
                chk({tag, "_timeout"}, 64'(timeout), 64'(p_to));
                chk({tag, "_xfer_count"}, 64'(xfer_count), 64'(exp_count));
                chk({tag, "_rdata"}, 64'(rdata), 64'(exp_rdata));
                post = 0;
            end else if (rdata_valid || slverr || timeout) bad++;
            if (Psel && Penable && q.size() > 0) begin
                Pready  = acc >= q[0].waits;
                Pslverr = Pready ? q[0].serr : 1'($urandom);
                Prdata  = Pready ? q[0].prdata : $urandom;
            end else begin
                Pready  = 1'($urandom);
                Pslverr = 1'($urandom);
                Prdata  = $urandom;
            end
            #1;
            if (pop && !transfer) bad++;
            if (Psel) begin
                if (q.size() == 0) bad++;
                else if (Paddr !== q[0].addr || Pwrite !== q[0].wr || Pwdata !== q[0].data) bad++;
                if (Penable) acc++;
                else setups++;
            end
            if (pop && q.size() > 0) begin
                h  = q.pop_front();
                to = h.waits >= TO;
                chk({tag, "_setup_cycles"}, 64'(setups), 64'(1));
                chk({tag, "_access_cycles"}, 64'(acc), to ? 64'(TO) : 64'(h.waits + 1));
                exp_count = exp_count + CW'(1);
                if (!h.wr && !to) exp_rdata = h.prdata;
                p_rv = !h.wr && !to;
                p_se = h.serr && !to;
                p_to = to;
                post = 1;
                acc = 0;
                setups = 0;
            end
        end
        chk({tag, "_drained"}, 64'(q.size()), 64'(0));
        chk({tag, "_no_glitch"}, 64'(bad), 64'(0));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        transfer = 1'b0;
        addr_temp = '0;
        data_temp = '0;
        Pready = 1'b0;
        Prdata = '0;
        Pslverr = 1'b0;
        repeat (2) @(negedge Pclk);
        #1;
        chk("rst_psel", 64'(Psel), 64'(0));
        chk("rst_penable", 64'(Penable), 64'(0));
        chk("rst_pop", 64'(pop), 64'(0));
        chk("rst_outs", 64'({Pwrite, rdata_valid, slverr, timeout}), 64'(0));
        chk("rst_paddr", 64'(Paddr), 64'(0));
        chk("rst_pwdata", 64'(Pwdata), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_count", 64'(xfer_count), 64'(0));
        rst = 1'b0;

        push(1, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0, 0);
        run("write", 50);
        chk("write_paddr_held", 64'(Paddr), 64'h1004);
        chk("write_count", 64'(xfer_count), 64'(1));

        push(0, 32'h0000_2000, 32'h0, 32'h1234_5678, 3, 0);
        run("read_ws3", 50);
        chk("read_rdata", 64'(rdata), 64'h1234_5678);

        push(1, 32'h0000_3008, 32'h5555_AAAA, 32'h0, 1, 1);
        run("slverr", 50);

        push(0, 32'h0000_4000, 32'h0, 32'hBAD0_BAD0, 100, 1);
        push(0, 32'h0000_4004, 32'h0, 32'h0BAD_F00D, 2, 0);
        run("timeout", 80);

        push(1, 32'h0000_5000, 32'h1111_1111, 32'h0, 0, 0);
        push(0, 32'h0000_5004, 32'h0, 32'h2222_2222, 0, 0);
        push(1, 32'h0000_5008, 32'h3333_3333, 32'h0, 1, 0);
        run("b2b", 80);

        push(0, 32'h3000_0040, 32'h0, 32'hCAFE_F00D, 3, 0);
        transfer = 1'b1;
        addr_temp = {1'b0, 32'h3000_0040};
        data_temp = '0;
        Pready = 1'b0;
        Pslverr = 1'b0;
        n = 0;
        do begin
            @(negedge Pclk);
            #1;
            n++;
        end while (!Penable && n < 10);
        chk("midrst_in_access", 64'(Penable), 64'(1));
        rst = 1'b1;
        #1;
        chk("midrst_psel", 64'(Psel), 64'(0));
        chk("midrst_penable", 64'(Penable), 64'(0));
        chk("midrst_pop", 64'(pop), 64'(0));
        chk("midrst_count", 64'(xfer_count), 64'(0));
        exp_count = '0;
        exp_rdata = '0;
        @(negedge Pclk);
        rst = 1'b0;
        run("replay", 50);
        chk("replay_addr", 64'(Paddr), 64'h3000_0040);

        repeat (30) push(1'($urandom), $urandom, $urandom, $urandom,
                         $urandom_range(0, 5), 1'($urandom));
        run("random", 2000);
        chk("final_count", 64'(xfer_count), 64'(exp_count));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
